// File: rtl/axi_matrix_writer.sv
// Streams a flattened matrix to memory as back-to-back AXI write bursts, one burst in flight.
// Optional macro AXI_MATRIX_WRITER_BRESP_CHECK_EN enables the sticky error flag on non-OKAY bresp.
module axi_matrix_writer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NUM_BLK   = 4,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDR_W-1:0]                    base_addr,
  input  logic [DATA_W*NUM_BLK*ROWS*COLS-1:0]  mat_data,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic [ADDR_W-1:0]                    awaddr,
  output logic [7:0]                           awlen,
  output logic                                 awvalid,
  input  logic                                 awready,
  output logic [DATA_W-1:0]                    wdata,
  output logic                                 wlast,
  output logic                                 wvalid,
  input  logic                                 wready,
  input  logic [1:0]                           bresp,
  input  logic                                 bvalid,
  output logic                                 bready
);

  localparam int unsigned N     = NUM_BLK * ROWS * COLS;
  localparam int unsigned IW    = $clog2(N + 1);
  localparam int unsigned BW    = $clog2(BURST_LEN + 1);
  localparam int unsigned BYTES = DATA_W / 8;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [7:0]          awlen_q, awlen_d;
  logic                awvalid_q, awvalid_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wlast_q, wlast_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [IW-1:0]       sel_c;
  logic [DATA_W-1:0]   word_c;

  // Word to present next: the current index when entering DATA, the following one mid-burst
  always_comb begin
    sel_c  = (state_q == S_DATA) ? idx_q + IW'(1) : idx_q;
    word_c = DATA_W'(mat_data >> (32'(sel_c) * DATA_W));
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    beat_d    = beat_q;
    base_d    = base_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awvalid_d = awvalid_q;
    wdata_d   = wdata_q;
    wlast_d   = wlast_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_ADDR;
          base_d    = base_addr;
          idx_d     = '0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          busy_d    = 1'b1;
          awvalid_d = 1'b1;
          awaddr_d  = base_addr;
          awlen_d   = 8'(BURST_LEN - 1);
        end
      end
      S_ADDR: begin
        if (awvalid_q && awready) begin
          state_d   = S_DATA;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wdata_d   = word_c;
          wlast_d   = (BURST_LEN == 1);
          beat_d    = '0;
        end
      end
      S_DATA: begin
        if (wvalid_q && wready) begin
          idx_d  = idx_q + IW'(1);
          beat_d = beat_q + BW'(1);
          if (wlast_q) begin
            state_d  = S_RESP;
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
          end else begin
            wdata_d = word_c;
            wlast_d = ((beat_q + BW'(1)) == BW'(BURST_LEN - 1));
          end
        end
      end
      S_RESP: begin
        if (bready_q && bvalid) begin
          bready_d = 1'b0;
`ifdef AXI_MATRIX_WRITER_BRESP_CHECK_EN
          if (bresp != 2'b00) error_d = 1'b1;
`endif
          if (idx_q == IW'(N)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d   = S_ADDR;
            awvalid_d = 1'b1;
            awaddr_d  = base_q + ADDR_W'(idx_q) * ADDR_W'(BYTES);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      beat_q    <= '0;
      base_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wlast_q   <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awvalid_q <= awvalid_d;
      wdata_q   <= wdata_d;
      wlast_q   <= wlast_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

`ifndef AXI_MATRIX_WRITER_BRESP_CHECK_EN
  // Response code is don't-care without the error check
  logic [1:0] bresp_unused_c;
  assign bresp_unused_c = bresp;
`endif

  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;
  assign awaddr  = awaddr_q;
  assign awlen   = awlen_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wlast   = wlast_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule

// File: doc/axi_matrix_writer.md
AXI_MATRIX_WRITER -- requirements
Module: axi_matrix_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of a data beat and of one matrix element; it SHALL be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the AXI address width.
REQ-003 SHALL have parameter NUM_BLK, default 4, meaning the number of matrix blocks.
REQ-004 SHALL have parameter ROWS, default 8, meaning the rows per block.
REQ-005 SHALL have parameter COLS, default 8, meaning the columns per block.
REQ-006 SHALL have parameter BURST_LEN, default 16, meaning the beats per burst; legal values are 1..256, and BURST_LEN SHALL divide N = NUM_BLK*ROWS*COLS.
REQ-007 SHALL have the following ports (name, direction, width, meaning):
 - clk, in, 1: the single clock.
 - rst, in, 1: reset; synchronous, active-high.
 - start, in, 1: starts one matrix write.
 - base_addr, in, ADDR_W: byte address of element 0.
 - mat_data, in, DATA_W*N: flattened matrix. Element i = (blk*ROWS+row)*COLS+col sits at bits [i*DATA_W +: DATA_W].
 - busy, out, 1: transfer in progress.
 - done, out, 1: the last transfer completed.
 - error, out, 1: a non-OKAY response was received.
 - awaddr, out, ADDR_W; awlen, out, 8; awvalid, out, 1; awready, in, 1: AXI write-address channel.
 - wdata, out, DATA_W; wlast, out, 1; wvalid, out, 1; wready, in, 1: AXI write-data channel.
 - bresp, in, 2; bvalid, in, 1; bready, out, 1: AXI write-response channel.

Function
REQ-008 SHALL implement states IDLE, ADDR, DATA, RESP and DONE, with exactly one burst outstanding at any time.
REQ-009 In IDLE or DONE, start=1 SHALL:
 - capture base_addr;
 - clear the element index, done and error;
 - enter ADDR.
REQ-010 In ADDR, the block SHALL do the following:
 - drive awvalid=1, awlen=BURST_LEN-1 and awaddr = base + idx*(DATA_W/8), computed modulo 2^ADDR_W;
 - on awvalid&&awready, drop awvalid the next cycle and enter DATA.
REQ-011 In DATA, the block SHALL do the following:
 - drive wvalid=1 with wdata = element idx;
 - advance idx by 1 on each wvalid&&wready;
 - hold wdata stable while wvalid=1 and wready=0.
REQ-012 wlast SHALL be 1 exactly on the BURST_LEN-th beat of each burst; after that beat's handshake, wvalid SHALL drop and the state SHALL become RESP.
REQ-013 In RESP, bready SHALL be 1. On bvalid&&bready:
 - if idx==N, go to DONE;
 - otherwise go to ADDR for the next burst.
REQ-014 No valid output SHALL depend combinationally on any ready input. A valid, once asserted, SHALL stay asserted with stable payload until its handshake.
REQ-015 Timing SHALL be:
 - awvalid asserts in the cycle after start is sampled;
 - wvalid asserts in the cycle after the AW handshake;
 - ADDR follows the B handshake with no idle cycle.
REQ-016 busy SHALL be 1 in ADDR, DATA and RESP, and 0 otherwise.
REQ-017 done SHALL rise on entry to DONE and SHALL hold until the next start or until reset.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 Changes to mat_data during busy=1 SHALL take effect on element words not yet presented; words already presented SHALL be unaffected.
REQ-020 bvalid asserted outside RESP SHALL be ignored; bready SHALL be 0 outside RESP.
REQ-021 Element index and beat counter widths SHALL be sized with $clog2 so that the count N+1 does not overflow.

Reset
REQ-022 While rst=1 at a clock edge, the block SHALL go to IDLE and drive the following outputs to 0:
 - awvalid, wvalid, wlast, bready;
 - busy, done, error;
 - awaddr, awlen, wdata.
REQ-023 A reset asserted mid-burst SHALL abandon the transfer immediately, with no completion of outstanding beats; the block SHALL then accept start normally.

Configuration
REQ-024 Macro AXI_MATRIX_WRITER_BRESP_CHECK_EN, when defined, SHALL make the block:
 - set error=1 (sticky until the next start or reset) when a B handshake carries bresp!=2'b00;
 - still complete the whole transfer.
REQ-025 When AXI_MATRIX_WRITER_BRESP_CHECK_EN is undefined, error SHALL be tied 0 and bresp SHALL be ignored.

Verification
REQ-026 Defaults, base 0x1000, element i=i, all ready=1, bvalid one cycle after wlast. The bench SHALL check:
 - 16 AW handshakes at 0x1000, 0x1040 ... 0x13C0, each with awlen=15;
 - 256 beats with wdata 0..255 in order;
 - wlast on every 16th beat;
 - done=1 after the 16th B handshake.
REQ-027 Random back-pressure on awready, wready and bvalid (~50% each). The bench SHALL check:
 - identical beat sequence to REQ-026;
 - awaddr and wdata never change while their valid=1 and ready=0.
REQ-028 BURST_LEN=1, NUM_BLK=1, ROWS=2, COLS=2. The bench SHALL check:
 - 4 bursts, each with awlen=0 and wlast on every beat;
 - 4 B handshakes;
 - done=1 afterwards.
REQ-029 With the macro defined, bresp=2'b10 on burst 3. The bench SHALL check:
 - error=1 from that handshake onward;
 - all 16 bursts still issued and done=1.
 Without the macro, the same stimulus SHALL give error=0 throughout.
REQ-030 Reset and restart sequence. The bench SHALL check:
 - rst=1 during beat 5 of burst 2 gives, next cycle, all outputs 0 and busy=0;
 - a new start, with base 0x0, restarts at awaddr=0x0 with element 0;
 - start pulsed while busy=1 has no effect.
